// File: rtl/fifo_2w_req_arb.sv
// fifo_2w_req_arb: round-robin arbiter granting up to two of NUM_REQ
// valid/ready requesters per cycle onto the two write ports of a fifo_2w.
// Ports: clk, rst_n (sync, active-low), arb_en, req_val/req_data/req_rdy,
// fifo_size (FIFO occupancy), w_val_0/1, w_data_0/1, w_src_0/1 (registered).
// Optional FIFO_2W_REQ_ARB_STATS_EN adds stats_clr and grant_cnt
// (one 16-bit saturating transfer counter per requester).
module fifo_2w_req_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_val,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
`ifdef FIFO_2W_REQ_ARB_STATS_EN
    input  logic                          stats_clr,
    output logic [NUM_REQ*16-1:0]         grant_cnt,
`endif
    input  logic [CNT_WIDTH-1:0]          fifo_size,
    output logic                          w_val_0,
    output logic [DATA_WIDTH-1:0]         w_data_0,
    output logic                          w_val_1,
    output logic [DATA_WIDTH-1:0]         w_data_1,
    output logic [IDX_WIDTH-1:0]          w_src_0,
    output logic [IDX_WIDTH-1:0]          w_src_1
);

    localparam logic [IDX_WIDTH:0] NREQ = (IDX_WIDTH+1)'(NUM_REQ);
    localparam logic signed [CNT_WIDTH:0] DEPTH_M1 =
        (CNT_WIDTH+1)'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [IDX_WIDTH-1:0]  rr_ptr;
    logic [1:0]            inflight;
    logic signed [CNT_WIDTH:0] space;
    logic [1:0]            slots;
    logic [IDX_WIDTH-1:0]  g0, g1;
    logic                  f0, f1;
    logic                  gnt0, gnt1;
    logic [IDX_WIDTH-1:0]  last, nxt;
    logic [IDX_WIDTH:0]    sum;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Words on the write ports now are not yet counted in fifo_size.
    assign inflight = {w_val_0 & w_val_1, w_val_0 ^ w_val_1};

    always_comb begin
        space = DEPTH_M1 - $signed({1'b0, fifo_size})
              - $signed({{(CNT_WIDTH-1){1'b0}}, inflight});
        slots = 2'd0;
        if (arb_en && space > 0)
            slots = (space == 1) ? 2'd1 : 2'd2;
    end

    // Scan from rr_ptr with wrap; first two valid requesters win.
    always_comb begin
        g0  = '0;
        g1  = '0;
        f0  = 1'b0;
        f1  = 1'b0;
        sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_WIDTH+1)'(k);
            if (sum >= NREQ)
                sum = sum - NREQ;
            if (req_val[sum[IDX_WIDTH-1:0]]) begin
                if (!f0) begin
                    f0 = 1'b1;
                    g0 = sum[IDX_WIDTH-1:0];
                end else if (!f1) begin
                    f1 = 1'b1;
                    g1 = sum[IDX_WIDTH-1:0];
                end
            end
        end
    end

    assign gnt0 = rst_n && f0 && (slots != 2'd0);
    assign gnt1 = rst_n && f1 && (slots == 2'd2);

    always_comb begin
        req_rdy = '0;
        if (gnt0) req_rdy[g0] = 1'b1;
        if (gnt1) req_rdy[g1] = 1'b1;
    end

    assign last = gnt1 ? g1 : g0;
    assign nxt  = (last == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : last + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            w_val_0  <= 1'b0;
            w_val_1  <= 1'b0;
            w_data_0 <= '0;
            w_data_1 <= '0;
            w_src_0  <= '0;
            w_src_1  <= '0;
        end else begin
            w_val_0 <= gnt0;
            w_val_1 <= gnt1;
            if (gnt0) begin
                w_data_0 <= data_arr[g0];
                w_src_0  <= g0;
                rr_ptr   <= nxt;
            end
            if (gnt1) begin
                w_data_1 <= data_arr[g1];
                w_src_1  <= g1;
            end
        end
    end

`ifdef FIFO_2W_REQ_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    // Clear dominates a same-cycle transfer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n || stats_clr)
                cnt[i] <= '0;
            else if (req_rdy[i] && cnt[i] != 16'hFFFF)
                cnt[i] <= cnt[i] + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        assign grant_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_fifo_2w_req_arb.sv
// tb_fifo_2w_req_arb: directed self-checking bench for fifo_2w_req_arb
// (NUM_REQ=4, DATA_WIDTH=32, FIFO_DEPTH=16).
module tb_fifo_2w_req_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         arb_en;
    logic [3:0]   req_val;
    logic [127:0] req_data;
    logic [3:0]   req_rdy;
    logic [4:0]   fifo_size;
    logic         w_val_0, w_val_1;
    logic [31:0]  w_data_0, w_data_1;
    logic [1:0]   w_src_0, w_src_1;
`ifdef FIFO_2W_REQ_ARB_STATS_EN
    logic         stats_clr;
    logic [63:0]  grant_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] d [4];

    always #5 clk = ~clk;

    fifo_2w_req_arb dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_val(req_val), .req_data(req_data), .req_rdy(req_rdy),
`ifdef FIFO_2W_REQ_ARB_STATS_EN
        .stats_clr(stats_clr), .grant_cnt(grant_cnt),
`endif
        .fifo_size(fifo_size),
        .w_val_0(w_val_0), .w_data_0(w_data_0),
        .w_val_1(w_val_1), .w_data_1(w_data_1),
        .w_src_0(w_src_0), .w_src_1(w_src_1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req_val = '0; arb_en = 1'b1; fifo_size = '0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_val = 4'hF; arb_en = 1'b1; fifo_size = '0;
        tick; tick;
        n_tests++; if (req_rdy !== 4'b0000) begin n_fail++;
            $display("FAIL rst_rdy got %b exp 0000", req_rdy); end
        n_tests++; if ({w_val_0, w_val_1} !== 2'b00) begin n_fail++;
            $display("FAIL rst_val got %b exp 00", {w_val_0, w_val_1}); end
        n_tests++; if ({w_data_0, w_data_1, w_src_0, w_src_1} !== '0) begin n_fail++;
            $display("FAIL rst_data got %h %h %0d %0d exp 0", w_data_0, w_data_1, w_src_0, w_src_1); end
        rst_n = 1'b1;
    endtask

    task automatic test_all_valid;
        do_reset;
        req_val = 4'hF; #1;
        n_tests++; if (req_rdy !== 4'b0011) begin n_fail++;
            $display("FAIL all_rdy0 got %b exp 0011", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1, w_src_0, w_src_1} !== 6'b11_00_01) begin n_fail++;
            $display("FAIL all_w0 got %b%b %0d %0d exp 11 0 1", w_val_0, w_val_1, w_src_0, w_src_1); end
        n_tests++; if (w_data_0 !== d[0] || w_data_1 !== d[1]) begin n_fail++;
            $display("FAIL all_d0 got %h %h exp %h %h", w_data_0, w_data_1, d[0], d[1]); end
        n_tests++; if (req_rdy !== 4'b1100) begin n_fail++;
            $display("FAIL all_rdy1 got %b exp 1100", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1, w_src_0, w_src_1} !== 6'b11_10_11) begin n_fail++;
            $display("FAIL all_w1 got %b%b %0d %0d exp 11 2 3", w_val_0, w_val_1, w_src_0, w_src_1); end
        n_tests++; if (w_data_0 !== d[2] || w_data_1 !== d[3]) begin n_fail++;
            $display("FAIL all_d1 got %h %h exp %h %h", w_data_0, w_data_1, d[2], d[3]); end
        n_tests++; if (req_rdy !== 4'b0011) begin n_fail++;
            $display("FAIL all_rdy2 got %b exp 0011", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1, w_src_0, w_src_1} !== 6'b11_00_01) begin n_fail++;
            $display("FAIL all_w2 got %b%b %0d %0d exp 11 0 1", w_val_0, w_val_1, w_src_0, w_src_1); end
    endtask

    task automatic test_space_one;
        do_reset;
        req_val = 4'b0110; fifo_size = 5'd14; #1;
        n_tests++; if (req_rdy !== 4'b0010) begin n_fail++;
            $display("FAIL sp1_rdy0 got %b exp 0010", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1, w_src_0} !== 4'b10_01) begin n_fail++;
            $display("FAIL sp1_w0 got %b%b %0d exp 10 1", w_val_0, w_val_1, w_src_0); end
        n_tests++; if (req_rdy !== 4'b0000) begin n_fail++;
            $display("FAIL sp1_rdy1 got %b exp 0000", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1} !== 2'b00 || w_data_0 !== d[1]) begin n_fail++;
            $display("FAIL sp1_hold got %b%b %h exp 00 %h", w_val_0, w_val_1, w_data_0, d[1]); end
        fifo_size = 5'd0; #1;
        n_tests++; if (req_rdy !== 4'b0110) begin n_fail++;
            $display("FAIL sp1_rdy2 got %b exp 0110", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1, w_src_0, w_src_1} !== 6'b11_10_01) begin n_fail++;
            $display("FAIL sp1_prio got %b%b %0d %0d exp 11 2 1", w_val_0, w_val_1, w_src_0, w_src_1); end
    endtask

    task automatic test_full;
        do_reset;
        req_val = 4'hF; fifo_size = 5'd15;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++; if (req_rdy !== 4'b0000 || w_val_0 !== 1'b0) begin n_fail++;
                $display("FAIL full_%0d got %b %b exp 0000 0", c, req_rdy, w_val_0); end
            tick;
        end
        fifo_size = 5'd0; #1;
        n_tests++; if (req_rdy !== 4'b0011) begin n_fail++;
            $display("FAIL full_resume got %b exp 0011", req_rdy); end
    endtask

    task automatic test_wrap;
        do_reset;
        req_val = 4'b0100; #1;
        n_tests++; if (req_rdy !== 4'b0100) begin n_fail++;
            $display("FAIL wrap_single got %b exp 0100", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1, w_src_0} !== 4'b10_10) begin n_fail++;
            $display("FAIL wrap_w0 got %b%b %0d exp 10 2", w_val_0, w_val_1, w_src_0); end
        req_val = 4'b1001; #1;
        n_tests++; if (req_rdy !== 4'b1001) begin n_fail++;
            $display("FAIL wrap_rdy got %b exp 1001", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1, w_src_0, w_src_1} !== 6'b11_11_00) begin n_fail++;
            $display("FAIL wrap_w1 got %b%b %0d %0d exp 11 3 0", w_val_0, w_val_1, w_src_0, w_src_1); end
        n_tests++; if (w_data_0 !== d[3] || w_data_1 !== d[0]) begin n_fail++;
            $display("FAIL wrap_d got %h %h exp %h %h", w_data_0, w_data_1, d[3], d[0]); end
        req_val = 4'hF; #1;
        n_tests++; if (req_rdy !== 4'b0110) begin n_fail++;
            $display("FAIL wrap_ptr got %b exp 0110", req_rdy); end
    endtask

    task automatic test_arb_en;
        do_reset;
        req_val = 4'hF; tick;
        arb_en = 1'b0; #1;
        n_tests++; if (req_rdy !== 4'b0000 || w_val_0 !== 1'b1) begin n_fail++;
            $display("FAIL en_drain got %b %b exp 0000 1", req_rdy, w_val_0); end
        tick;
        n_tests++; if ({w_val_0, w_val_1} !== 2'b00) begin n_fail++;
            $display("FAIL en_idle got %b%b exp 00", w_val_0, w_val_1); end
        arb_en = 1'b1; #1;
        n_tests++; if (req_rdy !== 4'b1100) begin n_fail++;
            $display("FAIL en_resume got %b exp 1100", req_rdy); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        req_val = 4'hF; tick;
        rst_n = 1'b0; #1;
        n_tests++; if (req_rdy !== 4'b0000) begin n_fail++;
            $display("FAIL mid_rdy got %b exp 0000", req_rdy); end
        tick;
        n_tests++; if ({w_val_0, w_val_1} !== 2'b00 || w_data_0 !== '0) begin n_fail++;
            $display("FAIL mid_val got %b%b %h exp 00 0", w_val_0, w_val_1, w_data_0); end
        rst_n = 1'b1; req_val = 4'b0110; #1;
        n_tests++; if (req_rdy !== 4'b0110) begin n_fail++;
            $display("FAIL mid_rdy2 got %b exp 0110", req_rdy); end
        tick;
        n_tests++; if (w_src_0 !== 2'd1 || w_src_1 !== 2'd2) begin n_fail++;
            $display("FAIL mid_src got %0d %0d exp 1 2", w_src_0, w_src_1); end
    endtask

`ifdef FIFO_2W_REQ_ARB_STATS_EN
    task automatic test_stats;
        stats_clr = 1'b0;
        do_reset;
        n_tests++; if (grant_cnt !== '0) begin n_fail++;
            $display("FAIL st_rst got %h exp 0", grant_cnt); end
        req_val = 4'b0100;
        tick; tick; tick;
        n_tests++; if (grant_cnt[47:32] !== 16'd3) begin n_fail++;
            $display("FAIL st_three got %0d exp 3", grant_cnt[47:32]); end
        for (int c = 0; c < 69997; c++) tick;
        n_tests++; if (grant_cnt[47:32] !== 16'hFFFF) begin n_fail++;
            $display("FAIL st_sat got %h exp ffff", grant_cnt[47:32]); end
        n_tests++; if ({grant_cnt[63:48], grant_cnt[31:0]} !== '0) begin n_fail++;
            $display("FAIL st_other got %h exp 0", grant_cnt); end
        stats_clr = 1'b1; #1;
        n_tests++; if (req_rdy !== 4'b0100) begin n_fail++;
            $display("FAIL st_rdy got %b exp 0100", req_rdy); end
        tick;
        n_tests++; if (grant_cnt[47:32] !== 16'd0) begin n_fail++;
            $display("FAIL st_clr got %h exp 0", grant_cnt[47:32]); end
        stats_clr = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin
            d[i] = 32'hDA7A_0000 + 32'(i * 17 + 1);
            req_data[i*32 +: 32] = d[i];
        end
`ifdef FIFO_2W_REQ_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset;
        test_all_valid;
        test_space_one;
        test_full;
        test_wrap;
        test_arb_en;
        test_reset_mid;
`ifdef FIFO_2W_REQ_ARB_STATS_EN
        test_stats;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
